// File: rtl/iob_gpio_debounce.sv
// GPIO input conditioner: per-bit synchroniser, stable-count debounce filter,
// debounced level with single-cycle rise/fall pulses and a masked rise event.
module iob_gpio_debounce #(
  parameter int unsigned GPIO_W      = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [CNT_W-1:0]  thresh,
  input  logic [GPIO_W-1:0] edge_mask,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] level_o,
  output logic [GPIO_W-1:0] rise_o,
  output logic [GPIO_W-1:0] fall_o,
  output logic              event_o
);

  localparam int unsigned CMP_W = CNT_W + 1;

  logic [SYNC_STAGES-1:0][GPIO_W-1:0] sync_q;
  logic [GPIO_W-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [GPIO_W-1:0]                  level_q, level_d;
  logic [GPIO_W-1:0]                  rise_q, rise_d;
  logic [GPIO_W-1:0]                  fall_q, fall_d;
  logic [GPIO_W-1:0]                  sync_s;
  logic [CNT_W-1:0]                   thr_eff;

  assign sync_s  = sync_q[SYNC_STAGES-1];
  assign thr_eff = (thresh == '0) ? CNT_W'(1) : thresh;

  // Synchroniser chain keeps running regardless of enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
    end
  end

  // Per-bit filter; the compare is one bit wider so cnt+1 cannot wrap
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    if (enable) begin
      for (int unsigned b = 0; b < GPIO_W; b++) begin
        if (sync_s[b] != level_q[b]) begin
          if ((CMP_W'(cnt_q[b]) + CMP_W'(1)) >= CMP_W'(thr_eff)) begin
            level_d[b] = sync_s[b];
            rise_d[b]  = sync_s[b];
            fall_d[b]  = ~sync_s[b];
          end else begin
            cnt_d[b] = cnt_q[b] + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign event_o = |(rise_q & edge_mask);

endmodule
